// File: rtl/forward_history_unit_pkg.sv
// Shared widths and entry/slot types for the forward history unit.
// The history slot carries its own enable so an idle cycle still ages the pipe.
package hash_pkg;
    localparam int DATA_WIDTH       = 4;
    localparam int KEY_WIDTH        = 2;
    localparam int HASH_ADR_WIDTH   = 2;
    localparam int NUMBER_OF_TABLES = 4;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
        logic                  valid;
    } entry_t;

    typedef struct packed {
        logic                      en;
        logic [HASH_ADR_WIDTH-1:0] adr;
        entry_t                    entry;
    } slot_t;
endpackage

// File: rtl/forward_history_unit_if.sv
// Read-result, write-commit and corrected-entry bundle for all tables.
interface forward_history_unit_if;
    import hash_pkg::*;

    logic [NUMBER_OF_TABLES-1:0][HASH_ADR_WIDTH-1:0] rd_hash_adr_i;
    logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]      rd_key_i;
    logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]     rd_data_i;
    logic [NUMBER_OF_TABLES-1:0]                     rd_is_valid_i;
    logic [NUMBER_OF_TABLES-1:0]                     rd_req_i;
    logic [NUMBER_OF_TABLES-1:0]                     wr_en_i;
    logic [NUMBER_OF_TABLES-1:0][HASH_ADR_WIDTH-1:0] wr_hash_adr_i;
    logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]      wr_key_i;
    logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]     wr_data_i;
    logic [NUMBER_OF_TABLES-1:0]                     wr_is_valid_i;
    logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]      correct_key;
    logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]     correct_data;
    logic [NUMBER_OF_TABLES-1:0]                     correct_is_valid;
    logic [NUMBER_OF_TABLES-1:0]                     correct_req;
    logic [NUMBER_OF_TABLES-1:0]                     forward_hit;

    modport slave (
        input  rd_hash_adr_i, rd_key_i, rd_data_i, rd_is_valid_i, rd_req_i,
        input  wr_en_i, wr_hash_adr_i, wr_key_i, wr_data_i, wr_is_valid_i,
        output correct_key, correct_data, correct_is_valid, correct_req, forward_hit
    );
    modport master (
        output rd_hash_adr_i, rd_key_i, rd_data_i, rd_is_valid_i, rd_req_i,
        output wr_en_i, wr_hash_adr_i, wr_key_i, wr_data_i, wr_is_valid_i,
        input  correct_key, correct_data, correct_is_valid, correct_req, forward_hit
    );
endinterface

// File: rtl/forward_history_unit_channel.sv
// One table's write history plus youngest-wins match against the incoming read.
module forward_history_channel
    import hash_pkg::*;
#(
    parameter int FORWARD_DEPTH  = 2,
    parameter bit BYPASS_CURRENT = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic [HASH_ADR_WIDTH-1:0] rd_adr_i,
    input  logic [KEY_WIDTH-1:0]      rd_key_i,
    input  logic [DATA_WIDTH-1:0]     rd_data_i,
    input  logic                      rd_valid_i,
    input  logic                      wr_en_i,
    input  logic [HASH_ADR_WIDTH-1:0] wr_adr_i,
    input  logic [KEY_WIDTH-1:0]      wr_key_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic                      wr_valid_i,
    output entry_t                    sel_o,
    output logic                      match_o
);
    entry_t rd_entry, wr_entry, hist_entry;
    logic   hist_hit;

    assign rd_entry = '{key: rd_key_i, data: rd_data_i, valid: rd_valid_i};
    assign wr_entry = '{key: wr_key_i, data: wr_data_i, valid: wr_valid_i};

    if (FORWARD_DEPTH > 0) begin : g_hist
        slot_t hist_q [FORWARD_DEPTH];
        slot_t slot_d;

        assign slot_d = '{en: wr_en_i, adr: wr_adr_i, entry: wr_entry};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < FORWARD_DEPTH; k++) hist_q[k] <= '0;
            end else if (clk_en) begin
                hist_q[0] <= slot_d;
                for (int k = 1; k < FORWARD_DEPTH; k++) hist_q[k] <= hist_q[k-1];
            end
        end

        // Walk oldest to youngest so the youngest matching slot overrides.
        always_comb begin
            hist_hit   = 1'b0;
            hist_entry = rd_entry;
            for (int k = FORWARD_DEPTH - 1; k >= 0; k--) begin
                if (hist_q[k].en && hist_q[k].adr == rd_adr_i) begin
                    hist_hit   = 1'b1;
                    hist_entry = hist_q[k].entry;
                end
            end
        end
    end else begin : g_nohist
        assign hist_hit   = 1'b0;
        assign hist_entry = rd_entry;
    end

    always_comb begin
        match_o = hist_hit;
        sel_o   = hist_entry;
        if (BYPASS_CURRENT && wr_en_i && wr_adr_i == rd_adr_i) begin
            match_o = 1'b1;
            sel_o   = wr_entry;
        end
    end
endmodule

// File: rtl/forward_history_unit.sv
// Per-table stale-read correction: history channels feeding one registered output stage.
module forward_history_unit
    import hash_pkg::*;
#(
    parameter int FORWARD_DEPTH  = 2,
    parameter bit BYPASS_CURRENT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    forward_history_unit_if.slave  bus
);
    entry_t [NUMBER_OF_TABLES-1:0] sel_d;
    logic   [NUMBER_OF_TABLES-1:0] match_d;

    logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]  key_q;
    logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0] data_q;
    logic [NUMBER_OF_TABLES-1:0]                 valid_q, req_q, hit_q;

    for (genvar t = 0; t < NUMBER_OF_TABLES; t++) begin : g_tbl
        forward_history_channel #(
            .FORWARD_DEPTH (FORWARD_DEPTH),
            .BYPASS_CURRENT(BYPASS_CURRENT)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .clk_en    (clk_en),
            .rd_adr_i  (bus.rd_hash_adr_i[t]),
            .rd_key_i  (bus.rd_key_i[t]),
            .rd_data_i (bus.rd_data_i[t]),
            .rd_valid_i(bus.rd_is_valid_i[t]),
            .wr_en_i   (bus.wr_en_i[t]),
            .wr_adr_i  (bus.wr_hash_adr_i[t]),
            .wr_key_i  (bus.wr_key_i[t]),
            .wr_data_i (bus.wr_data_i[t]),
            .wr_valid_i(bus.wr_is_valid_i[t]),
            .sel_o     (sel_d[t]),
            .match_o   (match_d[t])
        );
    end

    // Data always updates; only the hit flag is qualified by the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
            req_q   <= '0;
            hit_q   <= '0;
        end else if (clk_en) begin
            for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
                key_q[t]   <= sel_d[t].key;
                data_q[t]  <= sel_d[t].data;
                valid_q[t] <= sel_d[t].valid;
            end
            req_q <= bus.rd_req_i;
            hit_q <= match_d & bus.rd_req_i;
        end
    end

    assign bus.correct_key      = key_q;
    assign bus.correct_data     = data_q;
    assign bus.correct_is_valid = valid_q;
    assign bus.correct_req      = req_q;
    assign bus.forward_hit      = hit_q;
endmodule

// File: tb/tb_forward_history_unit.sv
// Bench: three variants (depth2/bypass, depth2/no-bypass, depth0/bypass) on shared stimulus.
module tb_forward_history_unit;
    import hash_pkg::*;
    localparam int NT = NUMBER_OF_TABLES;
    localparam int AW = HASH_ADR_WIDTH;
    localparam int KW = KEY_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    logic [NT-1:0]         wen, wvld, rreq, rvld;
    logic [NT-1:0][AW-1:0] wadr, radr;
    logic [NT-1:0][KW-1:0] wkey, rkey;
    logic [NT-1:0][DW-1:0] wdata, rdata;

    logic [2:0][NT-1:0][KW-1:0] act_key;
    logic [2:0][NT-1:0][DW-1:0] act_data;
    logic [2:0][NT-1:0]         act_vld, act_req, act_hit;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    forward_history_unit_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].rd_hash_adr_i = radr;
        assign bus[g].rd_key_i      = rkey;
        assign bus[g].rd_data_i     = rdata;
        assign bus[g].rd_is_valid_i = rvld;
        assign bus[g].rd_req_i      = rreq;
        assign bus[g].wr_en_i       = wen;
        assign bus[g].wr_hash_adr_i = wadr;
        assign bus[g].wr_key_i      = wkey;
        assign bus[g].wr_data_i     = wdata;
        assign bus[g].wr_is_valid_i = wvld;
        assign act_key[g]  = bus[g].correct_key;
        assign act_data[g] = bus[g].correct_data;
        assign act_vld[g]  = bus[g].correct_is_valid;
        assign act_req[g]  = bus[g].correct_req;
        assign act_hit[g]  = bus[g].forward_hit;

        forward_history_unit #(
            .FORWARD_DEPTH ((g == 2) ? 0 : 2),
            .BYPASS_CURRENT((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk   (clk),
            .reset (rst),
            .clk_en(ce),
            .bus   (bus[g])
        );
    end

    function automatic int fd_of(input int d);
        return (d == 2) ? 0 : 2;
    endfunction
    function automatic bit byp_of(input int d);
        return (d == 1) ? 1'b0 : 1'b1;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        string                      name;
        logic [2:0][NT-1:0]         mask;
        logic [2:0][NT-1:0][KW-1:0] key;
        logic [2:0][NT-1:0][DW-1:0] data;
        logic [2:0][NT-1:0]         vld, req, hit;
    } exp_t;
    exp_t sbq[$];
    exp_t pend;

    task automatic clr_pend(input string nm);
        pend.name = nm;
        pend.mask = '0; pend.key = '0; pend.data = '0;
        pend.vld  = '0; pend.req = '0; pend.hit  = '0;
    endtask

    task automatic add_exp(input int d, input int t, input int k, input int dt,
                           input int v, input int rq, input int h);
        pend.mask[d][t] = 1'b1;
        pend.key[d][t]  = k[KW-1:0];
        pend.data[d][t] = dt[DW-1:0];
        pend.vld[d][t]  = v[0];
        pend.req[d][t]  = rq[0];
        pend.hit[d][t]  = h[0];
    endtask

    task automatic check_exp(input exp_t e);
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < NT; t++) begin
                if (e.mask[d][t]) begin
                    n_cmp++;
                    if ({act_key[d][t], act_data[d][t], act_vld[d][t], act_req[d][t], act_hit[d][t]} !==
                        {e.key[d][t], e.data[d][t], e.vld[d][t], e.req[d][t], e.hit[d][t]}) begin
                        n_bad++;
                        $display("FAIL %s dut%0d tbl%0d: got key=%0h data=%0h vld=%b req=%b hit=%b, want key=%0h data=%0h vld=%b req=%b hit=%b",
                                 e.name, d, t, act_key[d][t], act_data[d][t], act_vld[d][t], act_req[d][t],
                                 act_hit[d][t], e.key[d][t], e.data[d][t], e.vld[d][t], e.req[d][t], e.hit[d][t]);
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (sbq.size() != 0) check_exp(sbq.pop_front());
    end

    task automatic idle();
        ce = 1'b1; wen = '0; wvld = '0; rreq = '0; rvld = '0;
        wadr = '0; radr = '0; wkey = '0; rkey = '0; wdata = '0; rdata = '0;
    endtask

    task automatic check_zero(input string nm, input int d);
        n_cmp++;
        if ({act_key[d], act_data[d], act_vld[d], act_req[d], act_hit[d]} !== '0) begin
            n_bad++;
            $display("FAIL %s dut%0d: got key=%h data=%h vld=%b req=%b hit=%b, want all zero",
                     nm, d, act_key[d], act_data[d], act_vld[d], act_req[d], act_hit[d]);
        end
    endtask

    // ---------------- directed vectors (DUT 0) ----------------
    typedef struct {
        logic ce; int tbl;
        logic wen; logic [AW-1:0] wadr; logic [KW-1:0] wkey; logic [DW-1:0] wdata; logic wvld;
        logic rreq; logic [AW-1:0] radr; logic [KW-1:0] rkey; logic [DW-1:0] rdata; logic rvld;
        logic chk; logic [KW-1:0] ekey; logic [DW-1:0] edata; logic evld, ereq, ehit;
    } vec_t;

    function automatic vec_t mkv(input int ce_, tbl, we, wa, wk, wd, wv, rq, ra, rk, rd, rv,
                                 chk, ek, ed, ev, erq, eh);
        vec_t v;
        v.ce = ce_[0]; v.tbl = tbl;
        v.wen = we[0]; v.wadr = wa[AW-1:0]; v.wkey = wk[KW-1:0]; v.wdata = wd[DW-1:0]; v.wvld = wv[0];
        v.rreq = rq[0]; v.radr = ra[AW-1:0]; v.rkey = rk[KW-1:0]; v.rdata = rd[DW-1:0]; v.rvld = rv[0];
        v.chk = chk[0]; v.ekey = ek[KW-1:0]; v.edata = ed[DW-1:0]; v.evld = ev[0];
        v.ereq = erq[0]; v.ehit = eh[0];
        return v;
    endfunction

    // ---------------- random-phase reference: timestamped write log ----------------
    typedef struct { int st; logic [AW-1:0] adr; logic [KW-1:0] key; logic [DW-1:0] data; logic vld; } wlog_t;
    wlog_t wlog [NT][$];
    int    ecnt;
    logic [2:0][NT-1:0][KW-1:0] last_key;
    logic [2:0][NT-1:0][DW-1:0] last_data;
    logic [2:0][NT-1:0]         last_vld, last_req, last_hit;

    task automatic model_step();
        int best; logic m;
        logic [KW-1:0] k; logic [DW-1:0] dt; logic v;
        clr_pend("random");
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < NT; t++) begin
                if (ce) begin
                    best = -1; m = 1'b0; k = rkey[t]; dt = rdata[t]; v = rvld[t];
                    for (int j = 0; j < wlog[t].size(); j++) begin
                        if (wlog[t][j].st >= ecnt - fd_of(d) && wlog[t][j].adr == radr[t] && wlog[t][j].st > best) begin
                            best = wlog[t][j].st; m = 1'b1;
                            k = wlog[t][j].key; dt = wlog[t][j].data; v = wlog[t][j].vld;
                        end
                    end
                    if (byp_of(d) && wen[t] && wadr[t] == radr[t]) begin
                        m = 1'b1; k = wkey[t]; dt = wdata[t]; v = wvld[t];
                    end
                    last_key[d][t] = k; last_data[d][t] = dt; last_vld[d][t] = v;
                    last_req[d][t] = rreq[t]; last_hit[d][t] = m & rreq[t];
                end
                add_exp(d, t, int'(last_key[d][t]), int'(last_data[d][t]), int'(last_vld[d][t]),
                        int'(last_req[d][t]), int'(last_hit[d][t]));
            end
        end
        if (ce) begin
            for (int t = 0; t < NT; t++) begin
                if (wen[t]) wlog[t].push_back('{ecnt, wadr[t], wkey[t], wdata[t], wvld[t]});
                while (wlog[t].size() > 4) void'(wlog[t].pop_front());
            end
            ecnt++;
        end
        sbq.push_back(pend);
    endtask

    vec_t vecs[16];

    initial begin
        idle();
        rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) check_zero("reset_state", d);
        @(negedge clk); rst = 1'b0;

        //                ce tb we wa wk wd  wv  rq ra rk rd rv  chk ek ed  ev rq h
        vecs[0]  = mkv(1, 2, 0, 0, 0, 0,  0,  1, 1, 2, 9, 1,  1, 2, 9,  1, 1, 0);
        vecs[1]  = mkv(1, 0, 1, 3, 1, 5,  1,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        vecs[2]  = mkv(1, 0, 0, 0, 0, 0,  0,  1, 3, 0, 0, 1,  1, 1, 5,  1, 1, 1);
        vecs[3]  = mkv(1, 0, 0, 0, 0, 0,  0,  1, 3, 0, 0, 1,  1, 1, 5,  1, 1, 1);
        vecs[4]  = mkv(1, 0, 0, 0, 0, 0,  0,  1, 3, 0, 0, 1,  1, 0, 0,  1, 1, 0);
        vecs[5]  = mkv(1, 1, 1, 2, 2, 4,  1,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        vecs[6]  = mkv(1, 1, 1, 2, 3, 7,  1,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        vecs[7]  = mkv(1, 1, 0, 0, 0, 0,  0,  1, 2, 0, 1, 1,  1, 3, 7,  1, 1, 1);
        vecs[8]  = mkv(1, 3, 1, 0, 1, 10, 1,  1, 0, 0, 3, 1,  1, 1, 10, 1, 1, 1);
        vecs[9]  = mkv(1, 0, 1, 1, 0, 0,  0,  0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0);
        vecs[10] = mkv(0, 0, 1, 1, 3, 15, 1,  1, 3, 1, 1, 1,  1, 0, 0,  0, 0, 0);
        vecs[11] = mkv(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        vecs[12] = mkv(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        vecs[13] = mkv(1, 0, 0, 0, 0, 0,  0,  1, 1, 2, 6, 1,  1, 0, 0,  0, 1, 1);
        vecs[14] = mkv(1, 1, 1, 0, 2, 12, 1,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        vecs[15] = mkv(1, 1, 0, 0, 0, 0,  0,  0, 0, 1, 2, 1,  1, 2, 12, 1, 0, 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle();
            ce = vecs[i].ce;
            wen[vecs[i].tbl]  = vecs[i].wen;  wadr[vecs[i].tbl]  = vecs[i].wadr;
            wkey[vecs[i].tbl] = vecs[i].wkey; wdata[vecs[i].tbl] = vecs[i].wdata;
            wvld[vecs[i].tbl] = vecs[i].wvld;
            rreq[vecs[i].tbl] = vecs[i].rreq; radr[vecs[i].tbl]  = vecs[i].radr;
            rkey[vecs[i].tbl] = vecs[i].rkey; rdata[vecs[i].tbl] = vecs[i].rdata;
            rvld[vecs[i].tbl] = vecs[i].rvld;
            if (vecs[i].chk) begin
                clr_pend($sformatf("vec%0d", i));
                add_exp(0, vecs[i].tbl, int'(vecs[i].ekey), int'(vecs[i].edata), int'(vecs[i].evld),
                        int'(vecs[i].ereq), int'(vecs[i].ehit));
                sbq.push_back(pend);
            end
        end

        // Same-cycle write/read: only the bypass variant forwards; current write beats slot0.
        @(negedge clk);
        idle();
        wen[3] = 1'b1; wadr[3] = 2'd1; wkey[3] = 2'd2; wdata[3] = 4'hB; wvld[3] = 1'b1;
        rreq[3] = 1'b1; radr[3] = 2'd1; rkey[3] = 2'd0; rdata[3] = 4'h3; rvld[3] = 1'b1;
        clr_pend("bypass_same_cycle");
        add_exp(0, 3, 2, 11, 1, 1, 1);
        add_exp(1, 3, 0, 3, 1, 1, 0);
        sbq.push_back(pend);
        @(negedge clk);
        wkey[3] = 2'd1; wdata[3] = 4'hD;
        clr_pend("bypass_vs_slot0");
        add_exp(0, 3, 1, 13, 1, 1, 1);
        add_exp(1, 3, 2, 11, 1, 1, 1);
        sbq.push_back(pend);

        // Mid-cycle asynchronous reset while a matching entry sits in history.
        @(negedge clk);
        idle();
        wen[2] = 1'b1; wadr[2] = 2'd3; wkey[2] = 2'd3; wdata[2] = 4'h6; wvld[2] = 1'b1;
        @(negedge clk);
        idle();
        rreq[2] = 1'b1; radr[2] = 2'd3; rkey[2] = 2'd1; rdata[2] = 4'h1; rvld[2] = 1'b1;
        clr_pend("pre_reset_hit");
        add_exp(0, 2, 3, 6, 1, 1, 1);
        sbq.push_back(pend);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check_zero("async_reset", d);
        @(negedge clk);
        rst = 1'b0;
        clr_pend("post_reset_ram");
        for (int d = 0; d < 3; d++) add_exp(d, 2, 1, 1, 1, 1, 0);
        sbq.push_back(pend);

        // Random traffic on all tables, checked against the write-log model.
        @(negedge clk);
        idle();
        @(negedge clk);
        for (int t = 0; t < NT; t++) wlog[t].delete();
        ecnt = 0;
        last_key = '0; last_data = '0; last_vld = '0; last_req = '0; last_hit = '0;
        for (int i = 0; i < 300; i++) begin
            if (i != 0) @(negedge clk);
            idle();
            ce = (i == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            for (int t = 0; t < NT; t++) begin
                wen[t]   = 1'($urandom_range(0, 1));
                wadr[t]  = AW'($urandom_range(0, 3));
                wkey[t]  = KW'($urandom_range(0, 3));
                wdata[t] = DW'($urandom_range(0, 15));
                wvld[t]  = ($urandom_range(0, 3) != 0);
                rreq[t]  = ($urandom_range(0, 3) != 0);
                radr[t]  = AW'($urandom_range(0, 3));
                rkey[t]  = KW'($urandom_range(0, 3));
                rdata[t] = DW'($urandom_range(0, 15));
                rvld[t]  = 1'($urandom_range(0, 1));
            end
            model_step();
        end

        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/forward_history_unit.md
Name: forward_history_unit

Overview:
- Parametrised, multi-cycle successor to the per-table forward position updater in the cuckoo hash pipeline.
- Keeps a per-table history of the last FORWARD_DEPTH committed memory writes (address, key, data, valid).
- Corrects stale block-RAM read results: a read whose address matches a pending or recent write returns the youngest written value.
- Sits between the table read stage and the compare/displace stage; replaces hand-instantiated per-cycle forwarders.

Parameters:
- DATA_WIDTH, 4, payload width per entry.
- KEY_WIDTH, 2, key width per entry.
- HASH_ADR_WIDTH, 2, address width of each table.
- NUMBER_OF_TABLES, 4, number of independent tables (channels).
- FORWARD_DEPTH, 2, number of history slots per table (write-to-read-visible latency of the RAM). 0 gives a pure registered pass-through.
- BYPASS_CURRENT, 1, if 1 the write presented in the same cycle also participates in matching as the youngest entry.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- clk_en  input  1  global pipeline enable; 0 freezes all state.
- rd_hash_adr_i  input  NUMBER_OF_TABLES x HASH_ADR_WIDTH  address whose RAM result arrives this cycle.
- rd_key_i / rd_data_i  input  NUMBER_OF_TABLES x KEY_WIDTH / DATA_WIDTH  raw RAM read result.
- rd_is_valid_i  input  NUMBER_OF_TABLES x 1  raw entry-occupied bit from RAM.
- rd_req_i  input  NUMBER_OF_TABLES x 1  read result is meaningful this cycle.
- wr_en_i  input  NUMBER_OF_TABLES x 1  write committed to the table this cycle.
- wr_hash_adr_i, wr_key_i, wr_data_i, wr_is_valid_i  input  per table  written address, key, data, occupied bit (0 means delete).
- correct_key / correct_data  output  NUMBER_OF_TABLES x KEY_WIDTH / DATA_WIDTH  corrected entry.
- correct_is_valid  output  NUMBER_OF_TABLES x 1  corrected occupied bit.
- correct_req  output  NUMBER_OF_TABLES x 1  registered copy of rd_req_i.
- forward_hit  output  NUMBER_OF_TABLES x 1  1 if the output came from history rather than RAM.

Behaviour:
- Reset (async, active-high): all history slot enables, all outputs and forward_hit go to 0. The reset is applied at once, even mid-operation. After release, history is empty.
- History: per-table shift register of FORWARD_DEPTH slots {en, adr, key, data, valid}.
  - On each clk edge with clk_en=1: slot0 <= {wr_en_i, wr fields}, slot[k] <= slot[k-1], oldest slot discarded.
  - A slot with wr_en_i=0 is shifted in with en=0.
- Match, combinational, per table: candidate set is the current write (if BYPASS_CURRENT=1 and wr_en_i=1) plus slots 0..FORWARD_DEPTH-1 with en=1 and adr==rd_hash_adr_i.
  - Priority: current write > slot0 > slot1 > ... (youngest wins).
  - No match: pass RAM values through.
- Output register, 1-cycle latency: on clk_en=1, correct_* <= selected key/data/valid, correct_req <= rd_req_i, forward_hit <= (match and rd_req_i).
  - When rd_req_i=0, data outputs still update but forward_hit=0. Consumers qualify data with correct_req.
- clk_en=0: history and outputs hold. A write presented in that cycle is ignored.
- A deletion write (wr_is_valid_i=0) forwards correct_is_valid=0, even if RAM reports valid.
- Tables are fully independent; no cross-table matching.
- FORWARD_DEPTH=0: no history storage; only the bypass path (if enabled) plus the output register.
- The same address written in consecutive cycles occupies two slots; the younger always wins.

Decomposition:
- Shared package (hash_pkg): entry struct typedef {key, data, valid} parameterised via the package constants, and the history slot struct {en, adr, entry}.
- One natural sub-module: forward_history_channel. It holds the single-table history and priority match, instantiated NUMBER_OF_TABLES times in a generate loop. The top level holds only the generate loop and the per-table output registers.

Test Plan:
- No writes; read table 2 adr 1 with RAM key=2, data=9, valid=1 and rd_req=1 -> one cycle later correct = {2, 9, 1}, forward_hit=0.
- Write table 0 adr 3, key 1, data 5 at cycle t; read adr 3 at t+1 with RAM stale data 0 -> correct_data=5, forward_hit=1 at t+2. Same read at t+FORWARD_DEPTH+1 -> RAM value, hit=0.
- Writes to table 1 adr 2 with data 4 then data 7 in consecutive cycles; read adr 2 next cycle -> data 7 (youngest wins).
- BYPASS_CURRENT=1: write and read of table 3 adr 0 (data 0xA) in the same cycle -> correct_data=0xA next cycle. With BYPASS_CURRENT=0 -> RAM value.
- Delete (wr_is_valid=0) table 0 adr 1, then read with RAM valid=1 -> correct_is_valid=0. Hold clk_en=0 for 3 cycles between write and read -> history is not aged, still a hit.
- Assert reset while history holds matching entries -> outputs 0 immediately. A subsequent read of the same address returns RAM values with hit=0.
